// File: rtl/ads131_spi_responder_if.sv
// SPI pin bundle between an SPI master and the ADS131A0X command-interface responder.
interface ads131_spi_responder_if;
  logic spi_sclk;
  logic spi_cs;
  logic spi_mosi;
  logic spi_miso;

  modport master (output spi_sclk, output spi_cs, output spi_mosi, input spi_miso);
  modport slave  (input spi_sclk, input spi_cs, input spi_mosi, output spi_miso);
endinterface

// File: rtl/ads131_spi_responder.sv
// ADS131A0X command-interface SPI slave (CPOL=0, CPHA=1): decodes 32-bit frames, replies next frame.
// Pins are 2-flop synchronised and edge-detected; SCLK high/low must each last >= 3 block clocks.
module ads131_spi_responder #(
  parameter int          WORD_BITS  = 32,
  parameter logic [7:0]  ID_VALUE   = 8'h04,
  parameter logic [31:0] READY_WORD = 32'hFF04_0000
) (
  input  logic                  synthesized_clock_4_167Mhz,
  input  logic                  reset_n,
  ads131_spi_responder_if.slave spi,
  output logic                  frame_done,
  output logic                  frame_error,
  output logic [31:0]           rx_word,
  output logic                  unlocked,
  output logic [1:0]            fsm_state
);

  localparam int             CW     = $clog2(WORD_BITS + 1);
  localparam logic [CW-1:0]  WB_C   = CW'(WORD_BITS);
  localparam logic [CW-1:0]  LAST_C = CW'(WORD_BITS - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2, ABORT = 2'd3} state_t;

  state_t        state;
  logic [1:0]    sclk_sync, cs_sync, mosi_sync;
  logic          sclk_q, cs_q;
  logic          sclk_rise, sclk_fall, cs_fall, cs_rise, mosi_s;
  logic          cs_pend, rise_seen, miso_q;
  logic [CW-1:0] bit_cnt;
  logic [31:0]   tx_shift, shift_rx, reply_word;
  logic [15:0]   cmd;
  logic [7:0]    regs [16];

  // CS synchroniser resets low so a frame already in progress at reset release is never entered.
  always_ff @(posedge synthesized_clock_4_167Mhz or negedge reset_n) begin
    if (!reset_n) begin
      sclk_sync <= '0;
      cs_sync   <= '0;
      mosi_sync <= '0;
      sclk_q    <= 1'b0;
      cs_q      <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[0], spi.spi_sclk};
      cs_sync   <= {cs_sync[0], spi.spi_cs};
      mosi_sync <= {mosi_sync[0], spi.spi_mosi};
      sclk_q    <= sclk_sync[1];
      cs_q      <= cs_sync[1];
    end
  end

  assign sclk_rise    = sclk_sync[1] & ~sclk_q;
  assign sclk_fall    = ~sclk_sync[1] & sclk_q;
  assign cs_fall      = ~cs_sync[1] & cs_q;
  assign cs_rise      = cs_sync[1] & ~cs_q;
  assign mosi_s       = mosi_sync[1];
  assign cmd          = shift_rx[31:16];
  assign spi.spi_miso = miso_q;
  assign fsm_state    = state;

  always_ff @(posedge synthesized_clock_4_167Mhz or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      cs_pend     <= 1'b0;
      rise_seen   <= 1'b0;
      miso_q      <= 1'b0;
      bit_cnt     <= '0;
      tx_shift    <= '0;
      shift_rx    <= '0;
      reply_word  <= READY_WORD;
      rx_word     <= '0;
      unlocked    <= 1'b0;
      frame_done  <= 1'b0;
      frame_error <= 1'b0;
      for (int i = 0; i < 16; i++) regs[i] <= (i == 0) ? ID_VALUE : 8'h00;
    end else begin
      frame_done  <= 1'b0;
      frame_error <= 1'b0;
      if (cs_fall && state != IDLE) cs_pend <= 1'b1;
      case (state)
        IDLE: begin
          miso_q <= 1'b0;
          if (cs_fall || cs_pend) begin
            cs_pend   <= 1'b0;
            tx_shift  <= reply_word;
            miso_q    <= reply_word[31];
            bit_cnt   <= '0;
            rise_seen <= 1'b0;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          if (cs_rise) begin
            miso_q <= 1'b0;
            state  <= (bit_cnt == WB_C) ? DONE : ABORT;
          end else begin
            // The first rising edge launches the MSB already on the pin; later ones advance.
            if (sclk_rise) begin
              rise_seen <= 1'b1;
              if (rise_seen) begin
                tx_shift <= tx_shift << 1;
                if (bit_cnt != WB_C) miso_q <= tx_shift[30];
              end
            end
            if (sclk_fall && bit_cnt != WB_C) begin
              shift_rx <= {shift_rx[30:0], mosi_s};
              bit_cnt  <= bit_cnt + 1'b1;
              if (bit_cnt == LAST_C) miso_q <= 1'b0;
            end
          end
        end
        DONE: begin
          rx_word    <= shift_rx;
          frame_done <= 1'b1;
          state      <= IDLE;
          if (!unlocked) begin
            if (cmd == 16'h0655) begin
              unlocked   <= 1'b1;
              reply_word <= 32'h0655_0000;
            end else begin
              reply_word <= READY_WORD;
            end
          end else if (cmd == 16'h0655) begin
            reply_word <= 32'h0655_0000;
          end else if (cmd == 16'h0555) begin
            unlocked   <= 1'b0;
            reply_word <= 32'h0555_0000;
          end else if (cmd == 16'h0000) begin
            reply_word <= 32'h2200_0000;
          end else if (cmd == 16'h0033) begin
            reply_word <= 32'h0033_0000;
          end else if (cmd[15:13] == 3'b001) begin
            reply_word <= {3'b001, cmd[12:8], regs[cmd[11:8]], 16'h0000};
          end else if (cmd[15:13] == 3'b010) begin
            // Register 0 holds the read-only ID, so a write there only echoes the ID.
            if (cmd[11:8] != 4'h0) begin
              regs[cmd[11:8]] <= cmd[7:0];
              reply_word      <= {3'b001, cmd[12:8], cmd[7:0], 16'h0000};
            end else begin
              reply_word      <= {3'b001, cmd[12:8], regs[0], 16'h0000};
            end
          end else begin
            reply_word <= 32'h0000_0000;
          end
        end
        ABORT: begin
          frame_error <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
